// File: rtl/ste_dmasnd.sv
// ste_dmasnd: DMA sound player -- fetches 16-bit words into a FIFO and plays them out as 8-bit stereo/mono samples.
// Ports: clk32/resb clock and async active-low reset; mhz8_en prescaler enable; play/loop/mono/rate control;
// frame_start/frame_end word-address frame; sreq/sload_n/mdin/fetch_addr fetch handshake;
// playing/sint/underrun status; audio_left/audio_right signed samples.
// Define DMASND_MONO_EN to honour the mono input; otherwise playback is always stereo.
module ste_dmasnd #(
  parameter int FIFO_DEPTH = 8,
  parameter int AW = 23
) (
  input  logic          clk32,
  input  logic          resb,
  input  logic          mhz8_en,
  input  logic          play,
  input  logic          loop,
  input  logic          mono,
  input  logic [1:0]    rate,
  input  logic [AW-1:0] frame_start,
  input  logic [AW-1:0] frame_end,
  output logic          sreq,
  input  logic          sload_n,
  input  logic [15:0]   mdin,
  output logic [AW-1:0] fetch_addr,
  output logic          playing,
  output logic          sint,
  output logic          underrun,
  output logic [7:0]    audio_left,
  output logic [7:0]    audio_right
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] end_r, addr_inc;
  logic [15:0] mem [FIFO_DEPTH];
  logic [15:0] head;
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [10:0] pre, lim;
  logic [7:0] smp_l, smp_r;
  logic sload_q, empty, full, act, flush, tick, take, push, pop, last, reload, sint_nx;
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  assign head = mem[rp];
  assign act = state == RUN || state == DRAIN;
  assign flush = state != IDLE && !play;
  assign lim = 11'd1280 >> rate;
  assign tick = act && mhz8_en && pre >= lim - 11'd1;
  assign take = tick && !empty;
  assign addr_inc = fetch_addr + AW'(1);
  // sload_q blocks a new request the cycle after a strobe: one request outstanding
  assign sreq = state == RUN && !full && fetch_addr != end_r && !sload_q;
  assign push = sreq && !sload_n;
  assign last = push && addr_inc == end_r;
  assign reload = state == START || (last && state_nx == RUN);
  assign playing = state != IDLE;
`ifdef DMASND_MONO_EN
  logic bp;
  // mono plays the high byte first; the word retires only after its low byte
  assign pop = take && (!mono || !bp);
  assign smp_l = mono ? (bp ? head[15:8] : head[7:0]) : head[15:8];
  assign smp_r = mono ? smp_l : head[7:0];
  always_ff @(posedge clk32 or negedge resb)
    if (!resb) bp <= 1'b1;
    else if (flush) bp <= 1'b1;
    else if (take) bp <= !mono || !bp;
`else
  logic unused_mono;
  assign unused_mono = mono;
  assign pop = take;
  assign smp_l = head[15:8];
  assign smp_r = head[7:0];
`endif
  always_comb begin
    state_nx = state;
    sint_nx = 1'b0;
    if (flush) state_nx = IDLE;
    else case (state)
      IDLE: state_nx = play ? START : IDLE;
      START: begin
        sint_nx = frame_start >= frame_end;
        state_nx = sint_nx ? IDLE : RUN;
      end
      RUN: begin
        sint_nx = last;
        state_nx = !last ? RUN : (loop && frame_start < frame_end) ? RUN : DRAIN;
      end
      default: state_nx = empty ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk32)
    if (push) mem[wp] <= mdin;
  always_ff @(posedge clk32 or negedge resb)
    if (!resb) begin
      state <= IDLE;
      end_r <= '0;
      fetch_addr <= '0;
      sint <= 1'b0;
      underrun <= 1'b0;
      sload_q <= 1'b0;
      pre <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      audio_left <= '0;
      audio_right <= '0;
    end else begin
      state <= state_nx;
      sint <= sint_nx;
      underrun <= state == RUN && !flush && tick && empty;
      sload_q <= !sload_n;
      pre <= (act && !flush && !tick) ? pre + 11'(mhz8_en) : '0;
      if (reload) begin
        fetch_addr <= frame_start;
        end_r <= frame_end;
      end else if (push) fetch_addr <= addr_inc;
      if (flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        audio_left <= '0;
        audio_right <= '0;
      end else begin
        wp <= wp + PW'(push);
        rp <= rp + PW'(pop);
        cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        if (take) begin
          audio_left <= smp_l;
          audio_right <= smp_r;
        end
      end
    end
endmodule

// File: tb/tb_ste_dmasnd.sv
// tb_ste_dmasnd: directed scenarios for ste_dmasnd with a fetch responder and an audio scoreboard.
module tb_ste_dmasnd;
  logic clk32 = 1'b0, resb = 1'b0, mhz8_en = 1'b1, play = 1'b0, loop = 1'b0, mono = 1'b0;
  logic [1:0] rate = 2'd0;
  logic [22:0] frame_start = '0, frame_end = '0;
  logic sreq, sload_n, playing, sint, underrun;
  logic [15:0] mdin;
  logic [22:0] fetch_addr, ea;
  logic [7:0] audio_left, audio_right;
  logic [15:0] word_q[$], exp_q[$];
  logic [15:0] w, e, cur, prev_a = '0;
  int checks = 0, errors = 0;
  int cyc = 0, nfetch = 0, nsint = 0, nund = 0, nchg = 0, last_cyc = 0;
  int fbase = 0, flen = 1, sq_cnt = 0;
  bit recycle = 0, mono_exp = 0, pv = 0;

  ste_dmasnd dut (
    .clk32(clk32), .resb(resb), .mhz8_en(mhz8_en), .play(play), .loop(loop), .mono(mono),
    .rate(rate), .frame_start(frame_start), .frame_end(frame_end), .sreq(sreq), .sload_n(sload_n),
    .mdin(mdin), .fetch_addr(fetch_addr), .playing(playing), .sint(sint), .underrun(underrun),
    .audio_left(audio_left), .audio_right(audio_right)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Memory responder: answers a request after it has been held two cycles; pushes expected samples.
  initial begin
    sload_n = 1'b1;
    mdin = '0;
    forever begin
      @(posedge clk32); #1;
      sload_n = 1'b1;
      if (resb && sreq) begin
        sq_cnt++;
        if (sq_cnt >= 2 && word_q.size() > 0) begin
          w = word_q.pop_front();
          if (recycle) word_q.push_back(w);
          ea = 23'(fbase + nfetch % flen);
          checks++;
          if (fetch_addr !== ea) begin
            errors++;
            $display("FAIL fetch_addr: got %0h want %0h (fetch %0d)", fetch_addr, ea, nfetch);
          end
          mdin = w;
          sload_n = 1'b0;
          nfetch++;
          sq_cnt = 0;
          if (mono_exp) begin
            exp_q.push_back({w[15:8], w[15:8]});
            exp_q.push_back({w[7:0], w[7:0]});
          end else exp_q.push_back(w);
        end
      end else sq_cnt = 0;
    end
  end

  // Scoreboard: every new non-zero audio value is matched against the expected queue.
  always @(negedge clk32) begin
    cur = {audio_left, audio_right};
    if (underrun) begin
      nund++;
      pv = 0;
    end
    if (sint) begin
      nsint++;
      checks++;
      if (nfetch % flen != 0) begin
        errors++;
        $display("FAIL sint_position: got fetch count %0d want multiple of %0d", nfetch, flen);
      end
    end
    if (cur != prev_a && cur != 16'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL audio_unexpected: got %h want none", cur);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL audio: got %h want %h", cur, e);
        end
      end
      if (pv) begin
        checks++;
        if (cyc - last_cyc != (1280 >> rate)) begin
          errors++;
          $display("FAIL tick_period: got %0d want %0d", cyc - last_cyc, 1280 >> rate);
        end
      end
      pv = 1;
      last_cyc = cyc;
      nchg++;
    end
    if (!playing) pv = 0;
    prev_a = cur;
  end

  task automatic do_reset;
    resb = 1'b0;
    play = 1'b0;
    loop = 1'b0;
    mono = 1'b0;
    repeat (2) begin @(posedge clk32); #1; end
    word_q.delete();
    exp_q.delete();
    nfetch = 0; nsint = 0; nund = 0; nchg = 0;
    recycle = 0; mono_exp = 0; flen = 1;
    resb = 1'b1;
    @(posedge clk32); #1;
  endtask

  task automatic wait_chg(input int n, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin @(posedge clk32); #1; ok = nchg >= n; end
  endtask

  task automatic wait_fall(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin @(posedge clk32); #1; ok = !playing; end
  endtask

  task automatic test_reset;
    bit bad;
    repeat (2) begin @(posedge clk32); #1; end
    checks++;
    if ({sreq, playing, sint, underrun} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {sreq, playing, sint, underrun});
    end
    checks++;
    if (fetch_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", fetch_addr); end
    checks++;
    if ({audio_left, audio_right} !== 16'h0) begin
      errors++;
      $display("FAIL reset_audio: got %h want 0", {audio_left, audio_right});
    end
    resb = 1'b1;
    bad = 0;
    repeat (8) begin @(posedge clk32); #1; bad |= sreq | playing; end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_after_reset: got activity want none"); end
  endtask

  task automatic test_stereo;
    bit ok;
    do_reset();
    frame_start = 23'h100; frame_end = 23'h104; fbase = 'h100; flen = 4; rate = 2'd0;
    word_q.push_back(16'h1122); word_q.push_back(16'h3344); word_q.push_back(16'h5566); word_q.push_back(16'h7788);
    play = 1'b1;
    wait_fall(8000, ok);
    play = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stereo_timeout: got playing=1 want 0"); end
    checks++;
    if (nfetch != 4) begin errors++; $display("FAIL stereo_fetches: got %0d want 4", nfetch); end
    checks++;
    if (nsint != 1) begin errors++; $display("FAIL stereo_sint: got %0d want 1", nsint); end
    checks++;
    if (nchg != 4) begin errors++; $display("FAIL stereo_ticks: got %0d want 4", nchg); end
    checks++;
    if (cyc - last_cyc > 3) begin errors++; $display("FAIL stereo_fall_delay: got %0d want <=3", cyc - last_cyc); end
    checks++;
    if ({audio_left, audio_right} !== 16'h7788) begin
      errors++;
      $display("FAIL stereo_final: got %h want 7788", {audio_left, audio_right});
    end
    checks++;
    if (nund != 0) begin errors++; $display("FAIL stereo_underrun: got %0d want 0", nund); end
  endtask

  task automatic test_loop;
    bit ok;
    do_reset();
    frame_start = 23'h100; frame_end = 23'h104; fbase = 'h100; flen = 4; rate = 2'd0;
    loop = 1'b1; recycle = 1;
    word_q.push_back(16'h1122); word_q.push_back(16'h3344); word_q.push_back(16'h5566); word_q.push_back(16'h7788);
    play = 1'b1;
    wait_chg(3, 5000, ok);
    repeat (20) begin @(posedge clk32); #1; end
    checks++;
    if (!ok) begin errors++; $display("FAIL loop_timeout: got %0d ticks want 3", nchg); end
    checks++;
    if (nund != 0) begin errors++; $display("FAIL loop_underrun: got %0d want 0", nund); end
    checks++;
    if (nfetch < 8) begin errors++; $display("FAIL loop_fetches: got %0d want >=8", nfetch); end
    checks++;
    if (nsint != nfetch / 4) begin errors++; $display("FAIL loop_sint: got %0d want %0d", nsint, nfetch / 4); end
    checks++;
    if (!playing) begin errors++; $display("FAIL loop_playing: got 0 want 1"); end
    play = 1'b0;
    @(posedge clk32); #1;
  endtask

  task automatic test_mono;
    bit ok;
    do_reset();
    frame_start = 23'h300; frame_end = 23'h301; fbase = 'h300; flen = 1; rate = 2'd3;
    mono = 1'b1;
`ifdef DMASND_MONO_EN
    mono_exp = 1;
`endif
    word_q.push_back(16'hA55A);
    play = 1'b1;
    wait_fall(1000, ok);
    play = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL mono_timeout: got playing=1 want 0"); end
    checks++;
    if (nchg != (mono_exp ? 2 : 1)) begin errors++; $display("FAIL mono_ticks: got %0d want %0d", nchg, mono_exp ? 2 : 1); end
    checks++;
    if ({audio_left, audio_right} !== (mono_exp ? 16'h5A5A : 16'hA55A)) begin
      errors++;
      $display("FAIL mono_final: got %h want %h", {audio_left, audio_right}, mono_exp ? 16'h5A5A : 16'hA55A);
    end
    checks++;
    if (cyc - last_cyc > 3) begin errors++; $display("FAIL mono_fall_delay: got %0d want <=3", cyc - last_cyc); end
  endtask

  task automatic test_underrun;
    bit ok;
    do_reset();
    frame_start = 23'h400; frame_end = 23'h404; fbase = 'h400; flen = 4; rate = 2'd3;
    word_q.push_back(16'h1357);
    play = 1'b1;
    wait_chg(1, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL underrun_first: got %0d ticks want 1", nchg); end
    repeat (400) begin @(posedge clk32); #1; end
    checks++;
    if (nund != 2) begin errors++; $display("FAIL underrun_count: got %0d want 2", nund); end
    checks++;
    if ({audio_left, audio_right} !== 16'h1357) begin
      errors++;
      $display("FAIL underrun_hold: got %h want 1357", {audio_left, audio_right});
    end
    word_q.push_back(16'h2468); word_q.push_back(16'h369C); word_q.push_back(16'h48AD);
    wait_fall(2000, ok);
    play = 1'b0;
    checks++;
    if (!ok || nchg != 4) begin errors++; $display("FAIL underrun_resume: got %0d ticks want 4", nchg); end
    checks++;
    if (nund != 2) begin errors++; $display("FAIL underrun_final: got %0d want 2", nund); end
  endtask

  task automatic test_empty_frame;
    bit got, seen, pl;
    do_reset();
    frame_start = 23'h200; frame_end = 23'h200;
    play = 1'b1;
    got = 0; seen = 0; pl = 1;
    for (int i = 0; i < 3 && !got; i++) begin
      @(posedge clk32); #1;
      seen |= sreq;
      if (sint) begin got = 1; pl = playing; end
    end
    play = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL empty_sint: got none want pulse"); end
    checks++;
    if (seen) begin errors++; $display("FAIL empty_sreq: got 1 want 0"); end
    checks++;
    if (pl) begin errors++; $display("FAIL empty_idle: got playing=1 want 0"); end
    repeat (3) begin @(posedge clk32); #1; end
    checks++;
    if (nsint != 1 || playing) begin errors++; $display("FAIL empty_after: got sint=%0d playing=%b want 1/0", nsint, playing); end
  endtask

  task automatic test_play_drop;
    bit ok;
    do_reset();
    frame_start = 23'h500; frame_end = 23'h510; fbase = 'h500; flen = 16; rate = 2'd3;
    word_q.push_back(16'h1111); word_q.push_back(16'h2222); word_q.push_back(16'h3333); word_q.push_back(16'h4444);
    play = 1'b1;
    wait_chg(1, 1000, ok);
    checks++;
    if (!ok || nfetch != 4) begin errors++; $display("FAIL drop_setup: got %0d fetches want 4", nfetch); end
    play = 1'b0;
    @(posedge clk32); #1;
    checks++;
    if ({sreq, playing, sint} !== 3'b0) begin
      errors++;
      $display("FAIL drop_flags: got %b want 000", {sreq, playing, sint});
    end
    checks++;
    if ({audio_left, audio_right} !== 16'h0) begin
      errors++;
      $display("FAIL drop_audio: got %h want 0", {audio_left, audio_right});
    end
    exp_q.delete();
    frame_start = 23'h600; frame_end = 23'h601; fbase = 'h600; flen = 1; nfetch = 0;
    word_q.push_back(16'h4242);
    play = 1'b1;
    wait_fall(1000, ok);
    play = 1'b0;
    checks++;
    if (!ok || nchg != 2 || {audio_left, audio_right} !== 16'h4242) begin
      errors++;
      $display("FAIL drop_flushed: got ticks=%0d audio=%h want 2/4242", nchg, {audio_left, audio_right});
    end
    checks++;
    if (nsint != 1) begin errors++; $display("FAIL drop_sint: got %0d want 1", nsint); end
  endtask

  task automatic test_reset_midrun;
    bit ok, bad;
    do_reset();
    frame_start = 23'h700; frame_end = 23'h708; fbase = 'h700; flen = 8; rate = 2'd3;
    word_q.push_back(16'h0102); word_q.push_back(16'h0304); word_q.push_back(16'h0506);
    play = 1'b1;
    wait_chg(1, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrun_setup: got %0d ticks want 1", nchg); end
    resb = 1'b0;
    #2;
    checks++;
    if ({sreq, playing, sint, underrun} !== 4'b0 || fetch_addr !== '0) begin
      errors++;
      $display("FAIL midrun_async: got flags=%b addr=%h want 0000/0", {sreq, playing, sint, underrun}, fetch_addr);
    end
    checks++;
    if ({audio_left, audio_right} !== 16'h0) begin
      errors++;
      $display("FAIL midrun_audio: got %h want 0", {audio_left, audio_right});
    end
    @(posedge clk32); #1;
    play = 1'b0;
    resb = 1'b1;
    bad = 0;
    repeat (5) begin @(posedge clk32); #1; bad |= sreq | playing; end
    checks++;
    if (bad) begin errors++; $display("FAIL midrun_release: got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_loop();
    test_mono();
    test_underrun();
    test_empty_frame();
    test_play_drop();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ste_dmasnd.md
STE_DMASND -- requirements
Module: ste_dmasnd

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning FIFO depth in 16-bit words (power of 2, 2..64).
REQ-002 SHALL have parameter AW, default 23, meaning word-address width (A[23:1]).
REQ-003 SHALL have ports:
  - clk32  in  1  system clock; the only clock.
  - resb  in  1  asynchronous, active-low reset.
  - mhz8_en  in  1  8 MHz clock enable.
  - play  in  1  play enable (level).
  - loop  in  1  repeat frame.
  - mono  in  1  mono mode.
  - rate  in  2  sample-rate select.
  - frame_start  in  AW  first word address.
  - frame_end  in  AW  word address one past the last word.
  - sreq  out  1  word-fetch request.
  - sload_n  in  1  fetched word valid, active-low, one-cycle strobe.
  - mdin  in  16  fetched word.
  - fetch_addr  out  AW  current fetch address.
  - playing  out  1  status.
  - sint  out  1  frame-end pulse.
  - underrun  out  1  underrun pulse.
  - audio_left  out  8  signed sample.
  - audio_right  out  8  signed sample.

Function
REQ-004 FSM SHALL have states IDLE, START, RUN and DRAIN.
  - IDLE->START on play=1.
  - START SHALL latch frame_start/frame_end and set fetch_addr=frame_start, then go to RUN.
  - If the latched frame_start>=frame_end in START: pulse sint, go to IDLE.
REQ-005 playing SHALL be 1 in START, RUN and DRAIN, and 0 in IDLE.
REQ-006 sreq SHALL be high in RUN when the FIFO has at least one free slot, fetch_addr!=latched end, and no sload_n low occurred in the previous cycle (one outstanding request max).
REQ-007 A cycle with sload_n=0 while sreq=1 SHALL push mdin into the FIFO and increment fetch_addr modulo 2^AW. sload_n=0 while sreq=0 SHALL be ignored.
REQ-008 When the incremented fetch_addr equals the latched end:
  - with loop=1: re-latch frame_start/frame_end, reload fetch_addr, pulse sint 1 cycle, stay in RUN;
  - with loop=0: pulse sint, go to DRAIN.
REQ-009 In DRAIN, sreq SHALL be 0. The FSM SHALL go to IDLE when the FIFO is empty and the final sample tick has been consumed.
REQ-010 play=0 in any non-IDLE state SHALL go to IDLE next cycle and flush the FIFO, with audio_left/right=0 and no sint.
REQ-011 The sample tick SHALL be every (1280>>rate) mhz8_en pulses; the prescaler SHALL be cleared in IDLE/START and run in RUN and DRAIN.
REQ-012 Stereo (mono=0): each tick SHALL pop one word; left=word[15:8], right=word[7:0].
REQ-013 Mono: each tick SHALL consume one byte, high byte first, to both channels; the word SHALL be popped after its low byte.
REQ-014 Audio outputs SHALL update the cycle after the tick.
REQ-015 A tick with an empty FIFO in RUN SHALL hold the previous samples and pulse underrun 1 cycle. In DRAIN an empty FIFO SHALL end play instead.
REQ-016 The FIFO SHALL accept a simultaneous push and pop. The FIFO full/empty condition SHALL be exact for count 0..FIFO_DEPTH.
REQ-017 Changes to frame_start/frame_end during RUN SHALL take effect only at the next START or loop reload.

Reset
REQ-018 resb=0 SHALL asynchronously force the following state:
  - FSM=IDLE;
  - FIFO empty;
  - prescaler=0;
  - byte pointer=high;
  - sreq=0, fetch_addr=0, playing=0, sint=0, underrun=0;
  - audio_left=audio_right=0.
REQ-019 Release of resb SHALL take effect on the next clk32 edge, with no fetch before play is sampled high.

Configuration
REQ-020 Macro DMASND_MONO_EN SHALL control mono support:
  - defined: mono input honoured per REQ-013;
  - undefined: mono ignored, always stereo, byte-pointer logic absent.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - start=0x100, end=0x104, loop=0, stereo, words 0x1122..0x7788 answered 2 cycles after sreq: exactly 4 fetches at 0x100..0x103, one sint, samples (0x11,0x22)..(0x77,0x88), playing falls after the 4th tick.
  - Same frame, loop=1: fetch_addr wraps 0x103->0x100, sint every 4 fetches, no underrun at rate=0.
  - Mono (macro defined), word 0xA55A: left=right=0xA5 at tick 1 and 0x5A at tick 2; pop occurs after tick 2.
  - sload_n withheld for 2 ticks, rate=3: underrun pulses twice, audio holds the last value.
  - start=end=0x200: sint pulse, no sreq, back to IDLE within 3 cycles.
  - play dropped with FIFO holding 3 words, or resb pulsed mid-RUN: next cycle sreq=0, audio=0, playing=0, FIFO empty.
